// File: rtl/regfile_writeback.sv
// regfile_writeback
// Write-side front end for the 32x32 register file. The single write port is
// shared by the single-cycle ALU path (A, always wins) and the long-latency
// load/multiply path (B, buffered in a FIFO and drained in A-idle cycles).
// A pending-register scoreboard tracks B-path results still in flight.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   a_valid/a_reg/a_data   ALU result (no backpressure; a_reg 0 = no request)
//   b_valid/b_ready        B-path result handshake (b_ready = FIFO not full)
//   b_reg/b_data           B-path result payload
//   issue_valid/issue_reg  B-path instruction issue, sets a scoreboard bit
//   writeReg/writeData     register file write address/data (registered)
//   regWrite               register file write enable (registered)
//   pending                scoreboard, bit n = register n outstanding on B
//   b_count                current FIFO occupancy
module regfile_writeback #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       a_valid,
   input  logic [4:0]                 a_reg,
   input  logic [31:0]                a_data,
   input  logic                       b_valid,
   output logic                       b_ready,
   input  logic [4:0]                 b_reg,
   input  logic [31:0]                b_data,
   input  logic                       issue_valid,
   input  logic [4:0]                 issue_reg,
   output logic [4:0]                 writeReg,
   output logic [31:0]                writeData,
   output logic                       regWrite,
   output logic [31:0]                pending,
   output logic [$clog2(DEPTH):0]     b_count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef struct packed {
      logic [4:0]  regAddr;
      logic [31:0] data;
   } bEntry_t;

   bEntry_t             fifoMem [DEPTH];
   logic [PtrW-1:0]     wrPtr;
   logic [PtrW-1:0]     rdPtr;
   logic [CntW-1:0]     count;
   bEntry_t             head;

   logic                aReq;
   logic                fifoFull;
   logic                fifoEmpty;
   logic                push;
   logic                pop;
   logic [31:0]         setMask;
   logic [31:0]         clrMask;
   logic [31:0]         pendingNext;

   // Request decode and port arbitration: A always wins, B drains when A idle.
   assign aReq      = a_valid && (a_reg != 5'd0);
   assign fifoFull  = (count == CntW'(DEPTH));
   assign fifoEmpty = (count == '0);
   assign b_ready   = !fifoFull;
   assign push      = b_valid && b_ready;
   assign pop       = !aReq && !fifoEmpty;
   assign head      = fifoMem[rdPtr];
   assign b_count   = count;

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem[wrPtr] <= '{regAddr: b_reg, data: b_data};
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PtrW'(1);
         if (pop)  rdPtr <= rdPtr + PtrW'(1);
         count <= count + CntW'(push) - CntW'(pop);
      end
   end

   // Write port: a popped reg-0 entry is consumed but produces no write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regWrite  <= 1'b0;
         writeReg  <= '0;
         writeData <= '0;
      end else if (aReq) begin
         regWrite  <= 1'b1;
         writeReg  <= a_reg;
         writeData <= a_data;
      end else if (pop) begin
         regWrite <= (head.regAddr != 5'd0);
         if (head.regAddr != 5'd0) begin
            writeReg  <= head.regAddr;
            writeData <= head.data;
         end
      end else begin
         regWrite <= 1'b0;
      end
   end

   // Scoreboard update: a new issue overrides a same-edge clear.
   always_comb begin
      setMask = '0;
      clrMask = '0;
      if (issue_valid) setMask[issue_reg] = 1'b1;
      if (pop)         clrMask[head.regAddr] = 1'b1;
      setMask[0] = 1'b0;
      pendingNext = (pending & ~clrMask) | setMask;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= pendingNext;
      end
   end

endmodule
